// File: rtl/cram_sequencer.sv
// Microcode address sequencer: forms the next CRAM address from J, dispatch, skip, trap and
// diagnostic sources, and keeps a circular CALL/RETURN stack with sticky error flags.
module cram_sequencer #(
    parameter int unsigned ADR_W       = 11,
    parameter int unsigned STACK_DEPTH = 16,
    parameter int unsigned DISP_W      = 4,
    localparam int unsigned PtrW       = $clog2(STACK_DEPTH),
    localparam int unsigned DepthW     = PtrW + 1
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              hold_i,
    input  logic              force_i,
    input  logic [ADR_W-1:0]  j_i,
    input  logic              disp_en_i,
    input  logic [DISP_W-1:0] disp_bits_i,
    input  logic              skip_en_i,
    input  logic              skip_cond_i,
    input  logic              call_i,
    input  logic              ret_i,
    input  logic              diag_load_i,
    input  logic [ADR_W-1:0]  diag_adr_i,
    input  logic              err_clr_i,
    output logic [ADR_W-1:0]  cradr_o,
    output logic [ADR_W-1:0]  loc_o,
    output logic [ADR_W-1:0]  sbr_ret_o,
    output logic [DepthW-1:0] stack_depth_o,
    output logic              stack_overflow_o,
    output logic              stack_underflow_o
);

    logic [ADR_W-1:0]  cradr_q, cradr_d;
    logic [ADR_W-1:0]  loc_q;
    logic [ADR_W-1:0]  stack_q [STACK_DEPTH];
    logic [ADR_W-1:0]  stack_d [STACK_DEPTH];
    logic [PtrW-1:0]   ptr_q, ptr_d, ptr_inc, ptr_dec;
    logic [DepthW-1:0] depth_q, depth_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;

    logic             empty, full, push, pop;
    logic [ADR_W-1:0] top;

    assign empty   = (depth_q == '0);
    assign full    = (depth_q == DepthW'(STACK_DEPTH));
    assign top     = empty ? '0 : stack_q[ptr_q];
    assign push    = (call_i | force_i) & ~diag_load_i;
    assign pop     = ret_i & ~force_i & ~diag_load_i;
    assign ptr_inc = ptr_q + PtrW'(1);
    assign ptr_dec = ptr_q - PtrW'(1);

    always_comb begin
        cradr_d = '0;
        if (diag_load_i) begin
            cradr_d = diag_adr_i;
        end else if (force_i) begin
            cradr_d = '1;
        end else begin
            cradr_d = j_i
                    | (pop ? top : '0)
                    | (disp_en_i ? ADR_W'(disp_bits_i) : '0)
                    | {{(ADR_W-1){1'b0}}, skip_en_i & skip_cond_i};
        end
    end

    // A new error in the same cycle as errClr overrides the clear.
    always_comb begin
        stack_d = stack_q;
        ptr_d   = ptr_q;
        depth_d = depth_q;
        ovf_d   = ovf_q & ~err_clr_i;
        unf_d   = unf_q & ~err_clr_i;
        if (push && pop) begin
            if (empty) begin
                unf_d            = 1'b1;
                stack_d[ptr_inc] = cradr_q;
                ptr_d            = ptr_inc;
                depth_d          = DepthW'(1);
            end else begin
                stack_d[ptr_q] = cradr_q;
            end
        end else if (push) begin
            stack_d[ptr_inc] = cradr_q;
            ptr_d            = ptr_inc;
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                depth_d = depth_q + DepthW'(1);
            end
        end else if (pop) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                ptr_d   = ptr_dec;
                depth_d = depth_q - DepthW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cradr_q <= '0;
            loc_q   <= '0;
            stack_q <= '{default: '0};
            ptr_q   <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (!hold_i) begin
            cradr_q <= cradr_d;
            loc_q   <= cradr_q;
            stack_q <= stack_d;
            ptr_q   <= ptr_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign cradr_o           = cradr_q;
    assign loc_o             = loc_q;
    assign sbr_ret_o         = top;
    assign stack_depth_o     = depth_q;
    assign stack_overflow_o  = ovf_q;
    assign stack_underflow_o = unf_q;

endmodule

// File: doc/cram_sequencer.md
# cram_sequencer

Parametrised microcode address sequencer: the generalised successor to the fixed 2K-word CRAM addressing logic. It forms the next CRAM address from the J field, dispatch and skip OR-ins, a forced trap address and a diagnostic load. It keeps a configurable-depth CALL/RETURN stack with depth reporting and sticky overflow/underflow detection. It sits between CRAM field decode (J, DISP, COND, CALL) and the CRAM storage address input.

## Interface
Parameters:
- ADR_W, 11, CRAM address width (2^ADR_W words)
- STACK_DEPTH, 16, number of return-stack entries (power of two, >=2)
- DISP_W, 4, width of the dispatch OR-in field (<= ADR_W)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- resetN  in  1  synchronous reset, active low
- hold  in  1  stall: no state changes while high (resetN still wins)
- force  in  1  trap: next address all ones, current address pushed
- J  in  ADR_W  CRAM J field
- dispEn  in  1  OR dispBits into low bits of next address
- dispBits  in  DISP_W  dispatch value selected upstream
- skipEn  in  1  skip condition enabled
- skipCond  in  1  selected skip condition; ORs into bit 0
- call  in  1  push current address
- ret  in  1  pop stack top, OR into next address
- diagLoad  in  1  load diagAdr as next address (diagnostic)
- diagAdr  in  ADR_W  diagnostic address
- errClr  in  1  clear sticky error flags
- CRADR  out  ADR_W  current CRAM address (registered)
- loc  out  ADR_W  previous CRADR (registered)
- sbrRet  out  ADR_W  stack top entry (0 when empty)
- stackDepth  out  clog2(STACK_DEPTH)+1  valid entry count
- stackOverflow  out  1  sticky: push attempted when full
- stackUnderflow  out  1  sticky: pop attempted when empty

## Operation
- Reset (resetN low at edge): CRADR=0, loc=0, stackDepth=0, all entries 0, both flags 0. Overrides hold and all other inputs.
- hold high: CRADR, loc, stack, depth, flags all hold; errClr ignored.
- Next-address priority, first match wins:
  - diagLoad: diagAdr. Stack untouched; call, ret and force ignored.
  - force: all ones.
  - otherwise: J | (ret ? popValue : 0) | (dispEn ? zero-extended dispBits : 0) | (skipEn & skipCond). All terms are OR-ed.
- Each non-held cycle: loc <= CRADR; CRADR <= next.
- Push condition is (call | force) & ~diagLoad. The pushed value is the current CRADR.
- Pop condition is ret & ~force & ~diagLoad. popValue is the top entry, or 0 when the stack is empty.
- Simultaneous push and pop: the top entry is replaced by the current CRADR, depth is unchanged, and the next address uses the old top.
  - Empty stack in this case: underflow is set, CRADR is pushed, and depth becomes 1.
- Push when full: the oldest entry is discarded (circular buffer), depth stays STACK_DEPTH, stackOverflow is set.
- Pop when empty: stackUnderflow is set, depth stays 0.
- Stack implementation: circular buffer with a top pointer that wraps modulo STACK_DEPTH.
- errClr clears both flags. A new error in the same cycle wins: that flag is set.

## Timing
- One-cycle latency from all inputs to CRADR, loc, stack and flags.
- sbrRet and stackDepth reflect registered state with no input-to-output combinational path.
- Combinational paths run from J, dispatch, skip, force and diag inputs to the next-address register only.
- No handshakes. Every non-held cycle consumes one microinstruction.

## Test plan
- Reset/sequence: resetN low, then J=0x010, 0x020 on successive cycles -> CRADR=0 at reset, then 0x010 and 0x020; loc trails by one cycle.
- Dispatch/skip: J=0x100, dispEn=1, dispBits=0xA, skipEn=1, skipCond=1 -> CRADR=0x10B. Repeat with skipCond=0 -> 0x10A.
- Call/return:
  - At CRADR=0x123, call with J=0x400 -> CRADR=0x400, sbrRet=0x123, depth 1.
  - Then ret with J=0x001 -> CRADR=0x123, depth 0.
- Force trap:
  - At CRADR=0x055, force=1 and ret=1 -> CRADR=0x7FF, sbrRet=0x055, no pop.
  - diagLoad=1 with force=1, diagAdr=0x333 -> CRADR=0x333, stack unchanged.
- Overflow/underflow, STACK_DEPTH=16:
  - 17 calls -> depth 16, overflow=1, and the 16 pops return the last 16 pushed values.
  - A 17th ret -> underflow=1, CRADR=J.
  - errClr -> both flags 0.
- Hold and mid-operation reset:
  - hold=1 for 3 cycles with call=1 -> no change.
  - resetN low while depth=5 -> depth 0, CRADR 0, flags 0 on the next edge.
